// File: rtl/scope_pkg.sv
// Shared constants and colour payload for the scope display path.
// Screen geometry, vertical scaling factors, graticule spacing and the
// 24-bit colours used by the trace renderer.
package scope_pkg;

    localparam int unsigned SCREEN_W    = 800;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned SCALE_MUL   = 15;
    localparam int unsigned SCALE_SHIFT = 7;
    localparam int unsigned GRID_X      = 80;
    localparam int unsigned GRID_Y      = 60;

    localparam int unsigned COORD_W  = 12;
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned PROD_W   = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_TRACE = 24'hFF_FF_00;
    localparam rgb_t COL_TRIG  = 24'hFF_00_00;
    localparam rgb_t COL_GRID  = 24'h40_40_40;
    localparam rgb_t COL_BG    = 24'h00_00_00;

endpackage

// File: rtl/sample_to_row.sv
// Maps a 12-bit sample to a screen row: full scale at the top, zero at the
// bottom. Purely combinational.
//   i_sample : buffered sample or threshold value
//   o_row_c  : screen row, 0 .. SCREEN_H-1
module sample_to_row
    import scope_pkg::*;
(
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic [COORD_W-1:0]  o_row_c
);

    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_lines;

    // Scale, clamp to the visible height, then flip so larger values sit higher.
    always_comb begin
        w_prod  = PROD_W'(i_sample) * PROD_W'(SCALE_MUL);
        w_lines = w_prod >> SCALE_SHIFT;
        if (w_lines > PROD_W'(SCREEN_H - 1)) begin
            w_lines = PROD_W'(SCREEN_H - 1);
        end
        o_row_c = COORD_W'(SCREEN_H - 1) - COORD_W'(w_lines);
    end

endmodule

// File: rtl/trace_renderer.sv
// Renders the buffered waveform, trigger-level line and graticule into VGA
// pixel colours with a fixed two-clock latency.
//   clock, reset           : pixel clock, synchronous active-low reset
//   pixelX/pixelY          : current pixel from the timing generator
//   pixelActive            : visible-area flag
//   hsyncIn/vsyncIn        : active-low syncs from the timing generator
//   triggerthreshold       : trigger level, captured once per frame
//   screenX/screenData     : sample buffer read address / data (1 clock later)
//   red/green/blue         : pixel colour
//   hsyncOut/vsyncOut      : syncs delayed to match colour
//   blankOut               : pixelActive delayed to match colour
module trace_renderer
    import scope_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               pixelActive,
    input  logic               hsyncIn,
    input  logic               vsyncIn,
    input  logic [SAMPLE_W-1:0] triggerthreshold,
    output logic [COORD_W-1:0] screenX,
    input  logic [SAMPLE_W-1:0] screenData,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic               hsyncOut,
    output logic               vsyncOut,
    output logic               blankOut
);

    logic               w_in_range;
    logic [COORD_W-1:0] w_cur_row;
    logic [COORD_W-1:0] w_trig_row;
    logic [COORD_W-1:0] w_lo;
    logic [COORD_W-1:0] w_hi;
    logic               w_trace_pix;
    logic               w_grid_pix;
    rgb_t               w_colour;

    logic [COORD_W-1:0] r_x1;
    logic [COORD_W-1:0] r_y1;
    logic               r_active1;
    logic               r_blank1;
    logic               r_hs1;
    logic               r_vs1;
    logic [COORD_W-1:0] r_prev_row;
    logic               r_prev_valid;
    logic [COORD_W-1:0] r_trig_row;
    rgb_t               r_rgb;
    logic               r_hs2;
    logic               r_vs2;
    logic               r_blank2;

    // Off-screen columns are treated as blank and never address the buffer.
    assign w_in_range = pixelActive && (pixelX < COORD_W'(SCREEN_W));
    assign screenX    = w_in_range ? pixelX : '0;

    sample_to_row u_trace_row (
        .i_sample (screenData),
        .o_row_c  (w_cur_row)
    );

    sample_to_row u_trig_row (
        .i_sample (triggerthreshold),
        .o_row_c  (w_trig_row)
    );

    // Stage 1: align pixel position and syncs with the returning buffer data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_x1      <= '0;
            r_y1      <= '0;
            r_active1 <= 1'b0;
            r_blank1  <= 1'b0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
        end else begin
            r_x1      <= pixelX;
            r_y1      <= pixelY;
            r_active1 <= w_in_range;
            r_blank1  <= pixelActive;
            r_hs1     <= hsyncIn;
            r_vs1     <= vsyncIn;
        end
    end

    // Trigger row latched at frame start so a threshold change cannot tear a frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_trig_row <= COORD_W'(SCREEN_H - 1);
        end else if (pixelActive && (pixelX == '0) && (pixelY == '0)) begin
            r_trig_row <= w_trig_row;
        end
    end

    // Previous column's row; cleared after the last column so lines don't join.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prev_row   <= '0;
            r_prev_valid <= 1'b0;
        end else if (r_active1) begin
            if (r_x1 == COORD_W'(SCREEN_W - 1)) begin
                r_prev_valid <= 1'b0;
            end else begin
                r_prev_row   <= w_cur_row;
                r_prev_valid <= 1'b1;
            end
        end
    end

    // Vertical segment joining the previous sample to the current one.
    always_comb begin
        w_lo = w_cur_row;
        w_hi = w_cur_row;
        if (r_prev_valid) begin
            w_lo = (r_prev_row < w_cur_row) ? r_prev_row : w_cur_row;
            w_hi = (r_prev_row < w_cur_row) ? w_cur_row : r_prev_row;
        end
        w_trace_pix = (r_y1 >= w_lo) && (r_y1 <= w_hi);
    end

    assign w_grid_pix = ((r_x1 % COORD_W'(GRID_X)) == '0)
                     || ((r_y1 % COORD_W'(GRID_Y)) == '0)
                     || (r_x1 == COORD_W'(SCREEN_W - 1))
                     || (r_y1 == COORD_W'(SCREEN_H - 1));

    // Colour priority: trace over trigger line over graticule.
    always_comb begin
        w_colour = COL_BG;
        if (r_active1) begin
            if (w_trace_pix) begin
                w_colour = COL_TRACE;
            end else if (r_y1 == r_trig_row) begin
                w_colour = COL_TRIG;
            end else if (w_grid_pix) begin
                w_colour = COL_GRID;
            end
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rgb    <= COL_BG;
            r_hs2    <= 1'b1;
            r_vs2    <= 1'b1;
            r_blank2 <= 1'b0;
        end else begin
            r_rgb    <= w_colour;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            r_blank2 <= r_blank1;
        end
    end

    assign red      = r_rgb.r;
    assign green    = r_rgb.g;
    assign blue     = r_rgb.b;
    assign hsyncOut = r_hs2;
    assign vsyncOut = r_vs2;
    assign blankOut = r_blank2;

endmodule

// File: tb/tb_trace_renderer.sv
// Bench for trace_renderer: a sample-buffer model answers screenX one clock
// later; a behavioural screen model predicts every output pixel.
module tb_trace_renderer;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] pixelX;
    logic [11:0] pixelY;
    logic        pixelActive;
    logic        hsyncIn;
    logic        vsyncIn;
    logic [11:0] triggerthreshold;
    logic [11:0] screenX;
    logic [11:0] screenData;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hsyncOut;
    logic        vsyncOut;
    logic        blankOut;

    always #5 clock = ~clock;

    trace_renderer dut (
        .clock            (clock),
        .reset            (reset),
        .pixelX           (pixelX),
        .pixelY           (pixelY),
        .pixelActive      (pixelActive),
        .hsyncIn          (hsyncIn),
        .vsyncIn          (vsyncIn),
        .triggerthreshold (triggerthreshold),
        .screenX          (screenX),
        .screenData       (screenData),
        .red              (red),
        .green            (green),
        .blue             (blue),
        .hsyncOut         (hsyncOut),
        .vsyncOut         (vsyncOut),
        .blankOut         (blankOut)
    );

    // Sample buffer: 800 entries, registered read.
    logic [11:0] mem [0:799];
    always @(posedge clock) screenData <= (screenX < 12'd800) ? mem[screenX] : 12'hBAD;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank;
    } obs_t;

    localparam obs_t RESET_OBS = {24'h000000, 1'b1, 1'b1, 1'b0};

    int   checks = 0;
    int   errors = 0;
    obs_t expq[$];

    // Model of the picture being drawn.
    int m_prev_row;
    bit m_prev_valid;
    int m_trig_row;

    function automatic int mrow(input int s);
        int v;
        v = (s * 15) / 128;
        if (v > 479) v = 479;
        return 479 - v;
    endfunction

    function automatic void model_reset();
        m_prev_row   = 0;
        m_prev_valid = 0;
        m_trig_row   = 479;
        expq.delete();
        expq.push_back(RESET_OBS);
        expq.push_back(RESET_OBS);
    endfunction

    function automatic obs_t model(input int x, input int y, input bit act,
                                   input bit hs, input bit vs, input int thr);
        obs_t e;
        int   cur, lo, hi;
        e.rgb = 24'h000000; e.hs = hs; e.vs = vs; e.blank = act;
        if (act && x == 0 && y == 0) m_trig_row = mrow(thr);
        if (act && x < 800) begin
            cur = mrow(int'(mem[x]));
            lo = cur; hi = cur;
            if (m_prev_valid) begin
                lo = (m_prev_row < cur) ? m_prev_row : cur;
                hi = (m_prev_row < cur) ? cur : m_prev_row;
            end
            if (y >= lo && y <= hi)                                  e.rgb = 24'hFFFF00;
            else if (y == m_trig_row)                                e.rgb = 24'hFF0000;
            else if (x % 80 == 0 || y % 60 == 0 || x == 799 || y == 479) e.rgb = 24'h404040;
            if (x == 799) m_prev_valid = 0;
            else begin m_prev_row = cur; m_prev_valid = 1; end
        end
        return e;
    endfunction

    // Drives one pixel at the falling edge and returns the output due now.
    task automatic drive(input int x, input int y, input bit act, input bit hs,
                         input bit vs, input int thr,
                         output bit have, output obs_t got, output obs_t exp);
        @(negedge clock);
        have = (expq.size() == 2);
        got  = {red, green, blue, hsyncOut, vsyncOut, blankOut};
        exp  = have ? expq.pop_front() : got;
        reset            = 1'b1;
        pixelX           = 12'(x);
        pixelY           = 12'(y);
        pixelActive      = act;
        hsyncIn          = hs;
        vsyncIn          = vs;
        triggerthreshold = 12'(thr);
        expq.push_back(model(x, y, act, hs, vs, thr));
    endtask

    int   thr_g = 0;
    bit   h;
    obs_t o, e;

    task automatic test_reset();
        for (int i = 0; i < 800; i++) mem[i] = 12'd0;
        reset = 1'b0; pixelX = 12'd5; pixelY = 12'd7; pixelActive = 1'b1;
        hsyncIn = 1'b0; vsyncIn = 1'b0; triggerthreshold = 12'd0;
        repeat (2) @(negedge clock);
        checks++;
        if ({red, green, blue, hsyncOut, vsyncOut, blankOut} !== RESET_OBS) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h",
                     {red, green, blue, hsyncOut, vsyncOut, blankOut}, RESET_OBS);
        end
        checks++;
        if (screenX !== 12'd5) begin
            errors++; $display("FAIL reset_screenx got=%0d exp=5", screenX);
        end
        model_reset();
    endtask

    task automatic test_flat();
        drive(900, 0, 0, 1, 1, thr_g, h, o, e);
        if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL flat_idle got=%h exp=%h", o, e); end end
        for (int i = 0; i < 800; i++) mem[i] = 12'd2048;
        for (int y = 237; y <= 241; y++) begin
            for (int x = 0; x < 800; x++) begin
                drive(x, y, 1, 1, 1, thr_g, h, o, e);
                if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL flat y=%0d x=%0d got=%h exp=%h", y, x, o, e); end end
            end
            for (int b = 0; b < 6; b++) begin
                drive(800 + b, y, 0, !(b >= 1 && b <= 3), 1, thr_g, h, o, e);
                if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL flat_hsync b=%0d got=%h exp=%h", b, o, e); end end
            end
        end
    endtask

    task automatic test_step();
        drive(900, 0, 0, 1, 1, thr_g, h, o, e);
        if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL step_idle got=%h exp=%h", o, e); end end
        for (int i = 0; i < 800; i++) mem[i] = 12'($urandom_range(0, 4095));
        mem[9] = 12'd0; mem[10] = 12'd4095;
        for (int y = 0; y < 480; y++) begin
            for (int x = 8; x <= 11; x++) begin
                drive(x, y, 1, 1, 1, thr_g, h, o, e);
                if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL step y=%0d x=%0d got=%h exp=%h", y, x, o, e); end end
            end
        end
    endtask

    task automatic test_trigger();
        int ys[6] = '{0, 127, 128, 358, 359, 360};
        drive(900, 0, 0, 1, 1, thr_g, h, o, e);
        if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL trig_idle got=%h exp=%h", o, e); end end
        for (int i = 0; i < 800; i++) mem[i] = 12'd4095;
        for (int f = 0; f < 2; f++) begin
            thr_g = 1024;
            for (int k = 0; k < 6; k++) begin
                if (f == 0 && k == 1) thr_g = 3000;
                if (f == 1) thr_g = 3000;
                for (int x = 0; x < 16; x++) begin
                    drive(x, ys[k], 1, 1, (k != 0), thr_g, h, o, e);
                    if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL trig f=%0d y=%0d x=%0d got=%h exp=%h", f, ys[k], x, o, e); end end
                end
            end
        end
    endtask

    task automatic test_grid();
        int px[6] = '{80, 81, 81, 80, 799, 400};
        int py[6] = '{5, 60, 5, 0, 200, 479};
        for (int k = 0; k < 6; k++) begin
            drive(px[k], py[k], 1, 1, 1, thr_g, h, o, e);
            if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL grid k=%0d got=%h exp=%h", k, o, e); end end
        end
    endtask

    task automatic test_reset_midline();
        drive(900, 0, 0, 1, 1, thr_g, h, o, e);
        if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL rst_idle got=%h exp=%h", o, e); end end
        for (int i = 0; i < 800; i++) mem[i] = 12'($urandom_range(0, 4095));
        mem[299] = 12'd4095; mem[300] = 12'd0;
        for (int x = 0; x < 300; x++) begin
            drive(x, 250, 1, 1, 1, thr_g, h, o, e);
            if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL rst_pre x=%0d got=%h exp=%h", x, o, e); end end
        end
        reset = 1'b0; hsyncIn = 1'b0;
        @(negedge clock);
        checks++;
        if ({red, green, blue, hsyncOut, vsyncOut, blankOut} !== RESET_OBS) begin
            errors++;
            $display("FAIL rst_mid got=%h exp=%h", {red, green, blue, hsyncOut, vsyncOut, blankOut}, RESET_OBS);
        end
        model_reset();
        for (int x = 300; x < 320; x++) begin
            drive(x, 250, 1, 1, 1, thr_g, h, o, e);
            if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL rst_post x=%0d got=%h exp=%h", x, o, e); end end
        end
    endtask

    task automatic test_inactive();
        int  xs[5]  = '{900, 900, 799, 800, 0};
        bit  act[5] = '{0, 1, 1, 1, 0};
        int  sx;
        for (int k = 0; k < 5; k++) begin
            drive(xs[k], 33, act[k], 1, 1, thr_g, h, o, e);
            if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL inact k=%0d got=%h exp=%h", k, o, e); end end
            #1;
            sx = (act[k] && xs[k] < 800) ? xs[k] : 0;
            checks++;
            if (int'(screenX) != sx) begin errors++; $display("FAIL screenx k=%0d got=%0d exp=%0d", k, screenX, sx); end
        end
    endtask

    task automatic test_random();
        int x = 0, y = 0, sx;
        bit act;
        drive(900, 0, 0, 1, 1, thr_g, h, o, e);
        if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL rnd_idle got=%h exp=%h", o, e); end end
        for (int i = 0; i < 800; i++) mem[i] = 12'($urandom_range(0, 4095));
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) x = $urandom_range(0, 850);
            else if (x >= 799) begin x = 0; y = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 479); end
            else x++;
            if ($urandom_range(0, 49) == 0) thr_g = $urandom_range(0, 4095);
            act = ($urandom_range(0, 9) != 0);
            drive(x, y, act, 1'($urandom), 1'($urandom), thr_g, h, o, e);
            if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL rnd n=%0d got=%h exp=%h", n, o, e); end end
            #1;
            sx = (act && x < 800) ? x : 0;
            checks++;
            if (int'(screenX) != sx) begin errors++; $display("FAIL rnd_screenx n=%0d got=%0d exp=%0d", n, screenX, sx); end
        end
        for (int k = 0; k < 2; k++) begin
            drive(900, 0, 0, 1, 1, thr_g, h, o, e);
            if (h) begin checks++; if (o !== e) begin errors++; $display("FAIL rnd_flush got=%h exp=%h", o, e); end end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_step();
        test_trigger();
        test_grid();
        test_reset_midline();
        test_inactive();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
